mux_rr_reg: RTL and testbench

Parametrised, registered N-channel W-bit multiplexer with valid/ready handshake. It generalises the datapath 4:1 mux to CHANNELS inputs, adding a one-entry output register and two selection modes: explicit select and fair round-robin among valid channels. It sits between multiple requesters and a single consumer, for example on a register-file write-back or memory-request merge point.

---
 rtl/mux_rr_reg.sv | 98 +++++++++
 tb/tb_mux_rr_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_reg.sv
// mux_rr_reg: registered N-channel W-bit multiplexer with valid/ready handshake.
// Channel selection is either explicit through sel (mode=0) or round-robin among
// valid channels (mode=1). A single output register holds the selected word.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   mode      0 = explicit select via sel, 1 = round-robin
//   sel       channel index used when mode=0
//   in_data   flat input bus, channel k at [k*WIDTH +: WIDTH]
//   in_valid  per-channel valid
//   in_ready  per-channel ready (one-hot or zero)
//   out_data  registered selected data
//   out_valid out_data holds an unconsumed word
//   out_ready consumer accepts out_data this cycle
//   out_chan  channel that supplied out_data
module mux_rr_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  logic [SEL_W-1:0]    rr_ptr;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                any_grant;
  logic                load_en;
  logic                found;
  int                  rr_idx;

  // The register can take a new word when it is empty or being drained this
  // cycle, which gives full throughput without a bubble.
  assign load_en = !out_valid || out_ready;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    rr_idx    = 0;
    if (!mode) begin
      // Out-of-range select (non power-of-two CHANNELS) grants nothing.
      if (int'(sel) < CHANNELS) begin
        grant[sel] = in_valid[sel];
        grant_idx  = sel;
      end
    end else begin
      // Scan starting at rr_ptr and wrapping; the first valid channel wins.
      for (int i = 0; i < CHANNELS; i++) begin
        rr_idx = int'(rr_ptr) + i;
        if (rr_idx >= CHANNELS) begin
          rr_idx = rr_idx - CHANNELS;
        end
        if (!found && in_valid[rr_idx]) begin
          found         = 1'b1;
          grant[rr_idx] = 1'b1;
          grant_idx     = SEL_W'(rr_idx);
        end
      end
    end
  end

  assign any_grant = |grant;
  assign in_ready  = load_en ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (any_grant) begin
        out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_chan  <= grant_idx;
        out_valid <= 1'b1;
        // Only round-robin grants advance the fairness pointer.
        if (mode) begin
          rr_ptr <= (int'(grant_idx) == CHANNELS-1) ? '0 : grant_idx + SEL_W'(1);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
module tb_mux_rr_reg;

  localparam int W  = 8;
  localparam int CH = 4;

  logic          clk;
  logic          rst_n;
  logic          mode;
  logic [1:0]    sel;
  logic [31:0]   in_data;
  logic [3:0]    in_valid;
  logic [3:0]    in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_chan;

  mux_rr_reg #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        md;
    logic [1:0]  s;
    logic [3:0]  iv;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  e_ready;
    logic        e_valid;
    logic [7:0]  e_data;
    logic [1:0]  e_chan;
  } vec_t;

  vec_t tbl[$];

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit       m_valid;
  int       m_data;
  int       m_chan;
  int       m_ptr;
  bit [3:0] m_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0; m_ready = '0;
  endtask

  // Grant from the rules: explicit select, or first valid channel in the
  // rotated order ptr, ptr+1, ... mod CH.
  task automatic model_comb();
    int order[$];
    bit [3:0] g;
    g = '0;
    if (!mode) begin
      if (int'(sel) < CH && in_valid[sel]) g[sel] = 1'b1;
    end else begin
      for (int i = 0; i < CH; i++) order.push_back((m_ptr + i) % CH);
      foreach (order[j]) begin
        if (g == 0 && in_valid[order[j]]) g[order[j]] = 1'b1;
      end
    end
    m_ready = (!m_valid || out_ready) ? g : 4'b0;
  endtask

  task automatic model_edge();
    bit load;
    load = !m_valid || out_ready;
    if (m_ready != 0) begin
      for (int k = 0; k < CH; k++) begin
        if (m_ready[k]) begin
          m_chan = k;
          m_data = int'(in_data[k*W +: W]);
        end
      end
      m_valid = 1;
      if (mode) m_ptr = (m_chan + 1) % CH;
    end else if (load) begin
      m_valid = 0;
    end
  endtask

  task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag);
    mode = v.md; sel = v.s; in_valid = v.iv; in_data = v.d; out_ready = v.ordy;
    @(negedge clk);
    model_comb();
    chk({tag, " in_ready"}, {28'b0, in_ready}, use_tbl ? {28'b0, v.e_ready} : {28'b0, m_ready});
    model_edge();
    @(posedge clk);
    #1;
    if (use_tbl) begin
      chk({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, v.e_valid});
      chk({tag, " out_data"},  {24'b0, out_data},  {24'b0, v.e_data});
      chk({tag, " out_chan"},  {30'b0, out_chan},  {30'b0, v.e_chan});
    end else begin
      chk({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, m_valid});
      if (m_valid) begin
        chk({tag, " out_data"}, {24'b0, out_data}, 32'(m_data));
        chk({tag, " out_chan"}, {30'b0, out_chan}, 32'(m_chan));
      end
    end
  endtask

  function automatic vec_t mk(logic md, logic [1:0] s, logic [3:0] iv, logic [31:0] d,
                              logic ordy, logic [3:0] er, logic ev, logic [7:0] ed,
                              logic [1:0] ec);
    vec_t v;
    v.md = md; v.s = s; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ready = er; v.e_valid = ev; v.e_data = ed; v.e_chan = ec;
    return v;
  endfunction

  localparam logic [31:0] D_A5 = 32'h00A5_0000;
  localparam logic [31:0] D_B6 = 32'h00B6_0000;
  localparam logic [31:0] D_C7 = 32'h00C7_0000;
  localparam logic [31:0] D_RR = 32'h1312_1110;

  initial begin
    vec_t v;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic [3:0]  xfer;

    // mode0 single channel, back-pressure, streaming
    tbl.push_back(mk(0, 2, 4'b0100, D_A5, 1, 4'b0100, 1, 8'hA5, 2));
    tbl.push_back(mk(0, 2, 4'b0100, D_A5, 0, 4'b0000, 1, 8'hA5, 2));
    tbl.push_back(mk(0, 2, 4'b0100, D_A5, 0, 4'b0000, 1, 8'hA5, 2));
    tbl.push_back(mk(0, 2, 4'b0100, D_A5, 0, 4'b0000, 1, 8'hA5, 2));
    tbl.push_back(mk(0, 2, 4'b0100, D_A5, 1, 4'b0100, 1, 8'hA5, 2));
    tbl.push_back(mk(0, 2, 4'b0100, D_B6, 1, 4'b0100, 1, 8'hB6, 2));
    tbl.push_back(mk(0, 2, 4'b0100, D_C7, 1, 4'b0100, 1, 8'hC7, 2));
    // round-robin fairness
    tbl.push_back(mk(1, 0, 4'b1111, D_RR, 1, 4'b0001, 1, 8'h10, 0));
    tbl.push_back(mk(1, 0, 4'b1111, D_RR, 1, 4'b0010, 1, 8'h11, 1));
    tbl.push_back(mk(1, 0, 4'b1111, D_RR, 1, 4'b0100, 1, 8'h12, 2));
    tbl.push_back(mk(1, 0, 4'b1111, D_RR, 1, 4'b1000, 1, 8'h13, 3));
    tbl.push_back(mk(1, 0, 4'b1111, D_RR, 1, 4'b0001, 1, 8'h10, 0));
    tbl.push_back(mk(1, 0, 4'b1111, D_RR, 1, 4'b0010, 1, 8'h11, 1));
    // skip and wrap: grant ch2 -> ptr 3, then only ch0/ch1 valid
    tbl.push_back(mk(1, 0, 4'b0100, D_RR, 1, 4'b0100, 1, 8'h12, 2));
    tbl.push_back(mk(1, 0, 4'b0011, D_RR, 1, 4'b0001, 1, 8'h10, 0));
    tbl.push_back(mk(1, 0, 4'b0011, D_RR, 1, 4'b0010, 1, 8'h11, 1));
    // invalid select and idle: out_valid drops, data/chan hold
    tbl.push_back(mk(0, 2, 4'b0011, D_RR, 1, 4'b0000, 0, 8'h11, 1));
    tbl.push_back(mk(0, 3, 4'b0111, D_RR, 1, 4'b0000, 0, 8'h11, 1));
    // mode switches: rr_ptr=2 preserved, mode0 transfer leaves it alone
    tbl.push_back(mk(1, 0, 4'b0001, D_RR, 1, 4'b0001, 1, 8'h10, 0));
    tbl.push_back(mk(0, 3, 4'b1000, D_RR, 1, 4'b1000, 1, 8'h13, 3));
    tbl.push_back(mk(1, 0, 4'b1111, D_RR, 1, 4'b0010, 1, 8'h11, 1));
    // stall with a word held
    tbl.push_back(mk(1, 0, 4'b1111, D_RR, 0, 4'b0000, 1, 8'h11, 1));

    // Reset for two cycles
    rst_n = 1'b0; mode = 0; sel = 2; in_valid = 4'b0100; in_data = D_A5; out_ready = 1;
    model_reset();
    #1;
    chk("reset async out_valid", {31'b0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset out_data",  {24'b0, out_data},  32'd0);
    chk("reset out_chan",  {30'b0, out_chan},  32'd0);
    chk("reset in_ready",  {28'b0, in_ready},  32'd0 | {28'b0, 4'b0100});
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));
    end

    // Reset asserted mid-cycle while a word is stalled
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset out_data",  {24'b0, out_data},  32'd0);
    chk("midreset out_chan",  {30'b0, out_chan},  32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v = mk(1, 0, 4'b1111, D_RR, 1, 4'b0001, 1, 8'h10, 0);
    run_cycle(v, 1'b1, "post_reset");
    v = mk(1, 0, 4'b1111, D_RR, 1, 4'b0010, 1, 8'h11, 1);
    run_cycle(v, 1'b1, "post_reset2");

    // Randomised phase; sources hold data/valid until transferred
    rv = 4'b0;
    rd = 32'b0;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < CH; k++) begin
        if (!rv[k]) begin
          rv[k] = ($urandom_range(0, 99) < 60);
          rd[k*W +: W] = 8'($urandom);
        end
      end
      v = mk(1'($urandom), 2'($urandom), rv, rd, ($urandom_range(0, 99) < 70), 0, 0, 0, 0);
      run_cycle(v, 1'b0, $sformatf("rand%0d", n));
      xfer = m_ready & rv;
      for (int k = 0; k < CH; k++) begin
        if (xfer[k]) rv[k] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
